// File: rtl/adc_buf_reader.sv
// -----------------------------------------------------------------------------
// adc_buf_reader
//
// Streams a block of captured ADC samples out of the single-port sample RAM.
// The block drives the RAM's address and enable pins and never writes to it.
// Samples leave on a valid/ready stream. A 2-entry FIFO absorbs the RAM's
// 1-cycle read latency, so downstream backpressure never drops a sample.
//
// Ports
//   clk, rst_n             system clock, asynchronous active-low reset
//   start                  single-cycle burst request (honoured only in IDLE)
//   start_addr, length     burst arguments, captured on an accepted start
//   busy                   accepted start .. done cycle, inclusive
//   done                   one-cycle pulse after the final sample transfers
//   err                    one-cycle pulse after a start with illegal arguments
//   ram_ce/ram_oce/ram_wre RAM clock enable / output enable / write enable
//   ram_ad                 RAM read address
//   ram_dout               RAM read data, valid one clk after ram_ce
//   m_data, m_valid,       output sample stream; m_last marks the final
//   m_ready, m_last        sample of the burst
// -----------------------------------------------------------------------------
module adc_buf_reader #(
  parameter int DEPTH  = 5120,
  parameter int ADDR_W = 13,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  output logic [ADDR_W-1:0] ram_ad,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;      // next RAM address to read
  logic [ADDR_W-1:0] remain_q;    // reads still to issue
  logic [ADDR_W-1:0] len_q;       // burst length, used to find the last sample
  logic [ADDR_W-1:0] out_cnt_q;   // samples already accepted downstream
  logic              in_flight_q; // a read was issued last cycle
  logic              err_q;

  logic [DATA_W-1:0] fifo_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q;

  logic       start_ok;
  logic       accept;
  logic       pop;
  logic       issue;
  logic [1:0] occupancy;

  assign start_ok = (start_addr < DEPTH_A) && (length != '0) && (length <= DEPTH_A);
  assign accept   = (state_q == IDLE) && start && start_ok;

  assign m_valid = (count_q != 2'd0);
  assign m_data  = fifo_q[rd_ptr_q];
  assign m_last  = m_valid && (out_cnt_q == len_q - ADDR_W'(1));
  assign pop     = m_valid && m_ready;

  // Entries held or on their way: the pending RAM read plus the FIFO. A pop
  // in this cycle frees a slot in time for the read issued now to land, which
  // is what sustains one sample per clock with m_ready held high.
  assign occupancy = {1'b0, in_flight_q} + count_q;
  assign issue     = (state_q == READ) &&
                     ((occupancy < 2'd2) || ((occupancy == 2'd2) && pop));

  assign ram_ce  = issue;
  assign ram_ad  = addr_q;
  assign ram_oce = 1'b1;
  assign ram_wre = 1'b0;

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign err  = err_q;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)                          state_d = READ;
      READ:    if (issue && remain_q == ADDR_W'(1)) state_d = DRAIN;
      DRAIN:   if (pop && m_last)                   state_d = DONE;
      DONE:                                         state_d = IDLE;
      default:                                      state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      len_q       <= '0;
      out_cnt_q   <= '0;
      in_flight_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_flight_q <= issue;
      err_q       <= (state_q == IDLE) && start && !start_ok;
      if (accept) begin
        addr_q    <= start_addr;
        remain_q  <= length;
        len_q     <= length;
        out_cnt_q <= '0;
      end else begin
        if (issue) begin
          addr_q   <= (addr_q == LAST_A) ? '0 : addr_q + ADDR_W'(1);
          remain_q <= remain_q - ADDR_W'(1);
        end
        if (pop) out_cnt_q <= out_cnt_q + ADDR_W'(1);
      end
    end
  end

  // Output FIFO: RAM data lands the cycle after its read was issued. The
  // issue rule above guarantees a push never finds the FIFO full.
  // NOTE: the two data entries sit on the async reset as well, so m_data
  // reads zero out of reset and a mid-burst reset leaves no stale sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (in_flight_q) begin
        fifo_q[wr_ptr_q] <= ram_dout;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      unique case ({in_flight_q, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_buf_reader.sv
// -----------------------------------------------------------------------------
// tb_adc_buf_reader
//
// Directed bench for adc_buf_reader. A RAM model answers reads one clk after
// ram_ce. Each accepted burst queues the address sequence and sample values it
// must produce; a compare process checks the DUT against those queues on every
// cycle, and the directed sequences pin latency, pulses and literal data.
// -----------------------------------------------------------------------------
module tb_adc_buf_reader;

  localparam int DEPTH  = 5120;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] length;
  logic              busy, done, err;
  logic              ram_ce, ram_oce, ram_wre;
  logic [ADDR_W-1:0] ram_ad;
  logic [DATA_W-1:0] ram_dout = '0;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  adc_buf_reader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .length(length), .busy(busy), .done(done), .err(err),
    .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre), .ram_ad(ram_ad),
    .ram_dout(ram_dout), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last)
  );

  always #5 clk = ~clk;

  // RAM contents: low 10 address bits folded with the bank bits, so the
  // upper bank differs from the lower one at the same offset.
  function automatic logic [DATA_W-1:0] ram_val(input int a);
    logic [ADDR_W-1:0] aa;
    aa = ADDR_W'(a);
    return aa[9:0] ^ {7'b0, aa[12:10]};
  endfunction

  always @(posedge clk) if (ram_ce) ram_dout <= ram_val(int'(ram_ad));

  int checks = 0;
  int errors = 0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state and logs
  int                exp_ad[$];
  logic [DATA_W-1:0] exp_q[$];
  int                iss_log[$];
  logic [DATA_W-1:0] acc_log[$];
  int issued = 0, accepted = 0, err_cnt = 0, done_cnt = 0, stall_cnt = 0;
  bit                prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data  = '0;

  // m_ready driver
  bit rnd_ready   = 1'b0;
  bit ready_fixed = 1'b1;
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    end
  end

  // Per-cycle compare against the model queues
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_ad.delete();
      exp_q.delete();
      issued     = 0;
      accepted   = 0;
      prev_stall = 1'b0;
    end else begin
      check(ram_oce === 1'b1, "ram_oce", int'(ram_oce), 1);
      check(ram_wre === 1'b0, "ram_wre", int'(ram_wre), 0);
      if (ram_ce) begin
        if (exp_ad.size() == 0) check(1'b0, "ram_ce_spurious", int'(ram_ad), -1);
        else begin
          int ea;
          ea = exp_ad.pop_front();
          check(int'(ram_ad) == ea, "ram_ad", int'(ram_ad), ea);
        end
        issued++;
        iss_log.push_back(int'(ram_ad));
      end
      if (prev_stall) check(m_valid && m_data == prev_data, "stall_hold", int'(m_data), int'(prev_data));
      if (m_valid) begin
        if (exp_q.size() == 0) check(1'b0, "valid_spurious", int'(m_data), -1);
        else begin
          check(m_data == exp_q[0], "m_data", int'(m_data), int'(exp_q[0]));
          check(m_last == (exp_q.size() == 1), "m_last", int'(m_last), int'(exp_q.size() == 1));
          if (m_ready) begin
            void'(exp_q.pop_front());
            accepted++;
            acc_log.push_back(m_data);
          end
        end
      end
      check((issued - accepted) <= 2, "credit", issued - accepted, 2);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (prev_stall) stall_cnt++;
      if (err) err_cnt++;
      if (done) begin
        done_cnt++;
        check(exp_q.size() == 0 && exp_ad.size() == 0, "done_early", exp_q.size(), 0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input int a, input int l);
    start      = 1'b1;
    start_addr = ADDR_W'(a);
    length     = ADDR_W'(l);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic start_burst(input int a, input int l);
    for (int i = 0; i < l; i++) begin
      exp_ad.push_back((a + i) % DEPTH);
      exp_q.push_back(ram_val((a + i) % DEPTH));
    end
    pulse_start(a, l);
  endtask

  // k counts negedges after the edge that sampled start (k=1 is the first).
  task automatic wait_burst(input int budget, output int first_v, output int done_k);
    first_v = -1;
    done_k  = -1;
    for (int k = 1; k <= budget; k++) begin
      tick();
      if (m_valid && first_v < 0) first_v = k;
      if (done) begin
        done_k = k;
        check(busy == 1'b1, "busy_at_done", int'(busy), 1);
        break;
      end
    end
    if (done_k < 0) check(1'b0, "burst_timeout", budget, 0);
  endtask

  task automatic clear_logs();
    iss_log.delete();
    acc_log.delete();
  endtask

  int fv, dk, e0, d0, n;
  int bad_a[3] = '{0, 5120, 0};
  int bad_l[3] = '{0, 4, 5121};

  initial begin
    rst_n = 1'b0; start = 1'b0; start_addr = '0; length = '0;
    repeat (3) tick();
    check(busy == 0,    "rst_busy",    int'(busy), 0);
    check(done == 0,    "rst_done",    int'(done), 0);
    check(err == 0,     "rst_err",     int'(err), 0);
    check(ram_ce == 0,  "rst_ram_ce",  int'(ram_ce), 0);
    check(ram_ad == 0,  "rst_ram_ad",  int'(ram_ad), 0);
    check(m_valid == 0, "rst_m_valid", int'(m_valid), 0);
    check(m_last == 0,  "rst_m_last",  int'(m_last), 0);
    check(m_data == 0,  "rst_m_data",  int'(m_data), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Basic burst: four samples back to back
    clear_logs();
    start_burst(0, 4);
    wait_burst(100, fv, dk);
    check(fv == 3, "t1_first_valid", fv, 3);
    check(dk == 7, "t1_done_cycle", dk, 7);
    check(acc_log.size() == 4, "t1_count", acc_log.size(), 4);
    if (acc_log.size() == 4) begin
      check(acc_log[0] == 10'h000, "t1_d0", int'(acc_log[0]), 0);
      check(acc_log[1] == 10'h001, "t1_d1", int'(acc_log[1]), 1);
      check(acc_log[2] == 10'h002, "t1_d2", int'(acc_log[2]), 2);
      check(acc_log[3] == 10'h003, "t1_d3", int'(acc_log[3]), 3);
    end
    tick();
    check(busy == 0, "t1_busy_after", int'(busy), 0);
    check(done == 0, "t1_done_after", int'(done), 0);

    // Address wrap from DEPTH-1 to 0
    clear_logs();
    start_burst(5118, 4);
    wait_burst(100, fv, dk);
    check(iss_log.size() == 4, "t2_issues", iss_log.size(), 4);
    if (iss_log.size() == 4 && acc_log.size() == 4) begin
      check(iss_log[0] == 5118, "t2_a0", iss_log[0], 5118);
      check(iss_log[1] == 5119, "t2_a1", iss_log[1], 5119);
      check(iss_log[2] == 0,    "t2_a2", iss_log[2], 0);
      check(iss_log[3] == 1,    "t2_a3", iss_log[3], 1);
      check(acc_log[0] == 10'h3FA, "t2_d0", int'(acc_log[0]), 'h3FA);
      check(acc_log[2] == 10'h000, "t2_d2", int'(acc_log[2]), 0);
    end
    tick();

    // Crossing into the upper bank
    clear_logs();
    start_burst(4094, 4);
    wait_burst(100, fv, dk);
    if (iss_log.size() == 4 && acc_log.size() == 4) begin
      check(iss_log[2] == 4096, "t3_a2", iss_log[2], 4096);
      check(acc_log[2] == 10'h004, "t3_d2", int'(acc_log[2]), 4);
    end else check(1'b0, "t3_count", acc_log.size(), 4);
    tick();

    // Full-depth burst under random backpressure
    clear_logs();
    stall_cnt = 0;
    rnd_ready = 1'b1;
    start_burst(3000, DEPTH);
    wait_burst(40000, fv, dk);
    rnd_ready = 1'b0;
    check(acc_log.size() == DEPTH, "t4_accepted", acc_log.size(), DEPTH);
    check(iss_log.size() == DEPTH, "t4_issued", iss_log.size(), DEPTH);
    check(exp_q.size() == 0, "t4_leftover", exp_q.size(), 0);
    check(stall_cnt > 0, "t4_stalls_seen", stall_cnt, 1);
    tick();

    // Illegal starts
    for (int i = 0; i < 3; i++) begin
      e0 = err_cnt;
      pulse_start(bad_a[i], bad_l[i]);
      tick();
      check(err == 1,  "bad_err_pulse", int'(err), 1);
      check(busy == 0, "bad_busy", int'(busy), 0);
      tick();
      check(err == 0,  "bad_err_clear", int'(err), 0);
      check(busy == 0, "bad_busy2", int'(busy), 0);
      repeat (2) tick();
      check(err_cnt - e0 == 1, "bad_err_once", err_cnt - e0, 1);
    end

    // start while busy is ignored
    clear_logs();
    e0 = err_cnt;
    d0 = done_cnt;
    start_burst(50, 6);
    tick();
    pulse_start(900, 3);
    wait_burst(100, fv, dk);
    check(acc_log.size() == 6, "t6_count", acc_log.size(), 6);
    check(err_cnt == e0, "t6_no_err", err_cnt - e0, 0);
    repeat (4) tick();
    check(busy == 0, "t6_idle_after", int'(busy), 0);
    check(done_cnt - d0 == 1, "t6_one_done", done_cnt - d0, 1);

    // Reset mid-burst, then a fresh burst
    clear_logs();
    start_burst(200, 10);
    n = 0;
    while (acc_log.size() < 3 && n < 50) begin
      tick();
      n++;
    end
    check(acc_log.size() == 3, "t7_pre_reset", acc_log.size(), 3);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check(m_valid == 0, "t7_valid_rst", int'(m_valid), 0);
    check(busy == 0,    "t7_busy_rst", int'(busy), 0);
    check(ram_ce == 0,  "t7_ce_rst", int'(ram_ce), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check(done_cnt == d0, "t7_no_done", done_cnt - d0, 0);
    check(busy == 0, "t7_busy_after", int'(busy), 0);
    clear_logs();
    start_burst(7, 2);
    wait_burst(100, fv, dk);
    check(fv == 3, "t7_first_valid", fv, 3);
    check(dk == 5, "t7_done_cycle", dk, 5);
    if (acc_log.size() == 2) check(acc_log[1] == 10'h008, "t7_d1", int'(acc_log[1]), 8);
    else check(1'b0, "t7_count", acc_log.size(), 2);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
